// File: rtl/ebpc_nz_splitter.sv
// ebpc_nz_splitter
// ----------------
// Input stage of the EBPC encoder. Each accepted activation word produces
// one zero/non-zero mask bit for the zero run-length coder, and non-zero
// words are also forwarded to the BPC encoder. At end of stream the mask
// beat carries the last flag, and once the BPC branch has drained a flush
// beat is sent to the BPC encoder.
//
// Optional feature: define EBPC_NZ_SPLITTER_STATS_EN to add the
// nz_cnt_o / z_cnt_o accepted-word counters.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), synchronous active-low reset
//   data_i, last_i       input word and end-of-stream marker
//   vld_i, rdy_o         input handshake
//   bpc_data_o           non-zero word toward the BPC encoder
//   bpc_vld_o            bpc_data_o valid
//   bpc_flush_o          end-of-stream flush request
//   bpc_rdy_i            BPC encoder ready (data and flush beats)
//   znz_o, znz_last_o    mask bit (1 = non-zero) and last-bit marker
//   znz_vld_o, znz_rdy_i mask handshake
//   idle_o               nothing pending, no stream in progress
//   nz_cnt_o, z_cnt_o    (optional) accepted non-zero / zero word counts
//
// Handshake rule for every interface here: a beat transfers on a rising
// edge where valid and ready are both high; the producer holds valid and
// payload stable until that happens, and valid never waits on ready.

module ebpc_nz_splitter #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              vld_i,
  output logic              rdy_o,
  output logic [DATA_W-1:0] bpc_data_o,
  output logic              bpc_vld_o,
  output logic              bpc_flush_o,
  input  logic              bpc_rdy_i,
  output logic              znz_o,
  output logic              znz_last_o,
  output logic              znz_vld_o,
  input  logic              znz_rdy_i,
  output logic              idle_o
`ifdef EBPC_NZ_SPLITTER_STATS_EN
  ,
  output logic [31:0]       nz_cnt_o,
  output logic [31:0]       z_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e            state_q, state_d;

  logic [DATA_W-1:0] bpc_data_q, bpc_data_d;
  logic              bpc_vld_q, bpc_vld_d;
  logic              znz_q, znz_d;
  logic              znz_last_q, znz_last_d;
  logic              znz_vld_q, znz_vld_d;
  logic              in_stream_q, in_stream_d;

  logic              nz;
  logic              bpc_free;
  logic              znz_free;
  logic              acc;
  logic              flush_done;

  assign nz       = |data_i;
  // A slot is free when empty or when its current beat leaves this cycle.
  assign bpc_free = !bpc_vld_q || bpc_rdy_i;
  assign znz_free = !znz_vld_q || znz_rdy_i;

  // Zero words never touch the bpc slot, so they bypass its back-pressure.
  assign rdy_o      = (state_q == ST_RUN) && znz_free && (bpc_free || !nz);
  assign acc        = vld_i && rdy_o;
  assign flush_done = (state_q == ST_FLUSH) && bpc_rdy_i;

  // State machine
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (acc && last_i) state_d = ST_DRAIN;
      // bpc_free also covers the cycle the final data beat completes.
      ST_DRAIN: if (bpc_free)      state_d = ST_FLUSH;
      ST_FLUSH: if (bpc_rdy_i)     state_d = ST_RUN;
      default:                     state_d = ST_RUN;
    endcase
  end

  // Output slots
  always_comb begin
    bpc_data_d  = bpc_data_q;
    bpc_vld_d   = bpc_vld_q;
    znz_d       = znz_q;
    znz_last_d  = znz_last_q;
    znz_vld_d   = znz_vld_q;
    in_stream_d = in_stream_q;

    if (acc) begin
      znz_d       = nz;
      znz_last_d  = last_i;
      znz_vld_d   = 1'b1;
      in_stream_d = !last_i;
    end else if (znz_rdy_i) begin
      znz_vld_d = 1'b0;
    end

    if (acc && nz) begin
      bpc_data_d = data_i;
      bpc_vld_d  = 1'b1;
    end else if (bpc_rdy_i) begin
      bpc_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      bpc_data_q  <= '0;
      bpc_vld_q   <= 1'b0;
      znz_q       <= 1'b0;
      znz_last_q  <= 1'b0;
      znz_vld_q   <= 1'b0;
      in_stream_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bpc_data_q  <= bpc_data_d;
      bpc_vld_q   <= bpc_vld_d;
      znz_q       <= znz_d;
      znz_last_q  <= znz_last_d;
      znz_vld_q   <= znz_vld_d;
      in_stream_q <= in_stream_d;
    end
  end

  assign bpc_data_o  = bpc_data_q;
  assign bpc_vld_o   = bpc_vld_q;
  // The FSM only enters FLUSH once the bpc slot is empty, so flush and
  // data valid are never high together.
  assign bpc_flush_o = (state_q == ST_FLUSH);
  assign znz_o       = znz_q;
  assign znz_last_o  = znz_last_q;
  assign znz_vld_o   = znz_vld_q;
  assign idle_o      = (state_q == ST_RUN) && !bpc_vld_q && !znz_vld_q && !in_stream_q;

`ifdef EBPC_NZ_SPLITTER_STATS_EN
  logic [31:0] nz_cnt_q, nz_cnt_d;
  logic [31:0] z_cnt_q, z_cnt_d;

  // Saturating counts; a flush completion starts the next stream at zero.
  // Accepts cannot happen in FLUSH, so clear and increment never collide.
  always_comb begin
    nz_cnt_d = nz_cnt_q;
    z_cnt_d  = z_cnt_q;
    if (flush_done) begin
      nz_cnt_d = '0;
      z_cnt_d  = '0;
    end else if (acc) begin
      if (nz) begin
        if (nz_cnt_q != 32'hFFFF_FFFF) nz_cnt_d = nz_cnt_q + 32'd1;
      end else begin
        if (z_cnt_q != 32'hFFFF_FFFF) z_cnt_d = z_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      nz_cnt_q <= '0;
      z_cnt_q  <= '0;
    end else begin
      nz_cnt_q <= nz_cnt_d;
      z_cnt_q  <= z_cnt_d;
    end
  end

  assign nz_cnt_o = nz_cnt_q;
  assign z_cnt_o  = z_cnt_q;
`else
  // flush_done only feeds the optional counters.
  logic unused_flush_done;
  assign unused_flush_done = flush_done;
`endif

endmodule
